// File: rtl/uart_core_if.sv
// Byte-side and serial-line bundle for uart_core.
// The core takes the slave view; the user logic (or a bench) takes the master view.
interface uart_core_if;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       rx;
   logic       tx;
   logic [7:0] rx_data;
   logic       tx_ready;
   logic       rx_ready;
   logic       frame_err;

   modport master (
      output tx_req, tx_data, rx,
      input  tx, rx_data, tx_ready, rx_ready, frame_err
   );

   modport slave (
      input  tx_req, tx_data, rx,
      output tx, rx_data, tx_ready, rx_ready, frame_err
   );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8-bit UART: 1 start, 8 data LSB first, 1 stop; independent TX and RX FSMs.
// Define UART_CORE_PARITY_EN to add an even parity bit after bit 7 on both directions.
module uart_core #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   uart_core_if.slave  bus
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

`ifdef UART_CORE_PARITY_EN
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   tx_state_t   tx_state_reg, tx_state_next;
   logic [15:0] tx_cnt_reg, tx_cnt_next;
   logic [2:0]  tx_idx_reg, tx_idx_next;
   logic [7:0]  tx_shift_reg, tx_shift_next;
   logic        tx_line_reg, tx_line_next;
   logic        tx_done;
   logic        tx_cnt_zero;
`ifdef UART_CORE_PARITY_EN
   logic        tx_par_reg, tx_par_next;
`endif

   assign tx_cnt_zero = (tx_cnt_reg == 16'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_reg <= TX_IDLE;
         tx_cnt_reg   <= 16'd0;
         tx_idx_reg   <= 3'd0;
         tx_shift_reg <= 8'h00;
         tx_line_reg  <= 1'b1;
`ifdef UART_CORE_PARITY_EN
         tx_par_reg   <= 1'b0;
`endif
      end else begin
         tx_state_reg <= tx_state_next;
         tx_cnt_reg   <= tx_cnt_next;
         tx_idx_reg   <= tx_idx_next;
         tx_shift_reg <= tx_shift_next;
         tx_line_reg  <= tx_line_next;
`ifdef UART_CORE_PARITY_EN
         tx_par_reg   <= tx_par_next;
`endif
      end
   end

   // The serial line is registered: each state loads the level of the next bit
   // on the edge that ends the current one, so tx never glitches.
   always_comb begin
      tx_state_next = tx_state_reg;
      tx_cnt_next   = tx_cnt_reg;
      tx_idx_next   = tx_idx_reg;
      tx_shift_next = tx_shift_reg;
      tx_line_next  = tx_line_reg;
      tx_done       = 1'b0;
`ifdef UART_CORE_PARITY_EN
      tx_par_next   = tx_par_reg;
`endif
      case (tx_state_reg)
         TX_IDLE: begin
            tx_line_next = 1'b1;
            if (bus.tx_req) begin
               tx_shift_next = bus.tx_data;
`ifdef UART_CORE_PARITY_EN
               tx_par_next   = ^bus.tx_data;
`endif
               tx_cnt_next   = BIT_LAST;
               tx_idx_next   = 3'd0;
               tx_line_next  = 1'b0;
               tx_state_next = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_zero) begin
               tx_cnt_next   = BIT_LAST;
               tx_line_next  = tx_shift_reg[0];
               tx_state_next = TX_DATA;
            end else begin
               tx_cnt_next = tx_cnt_reg - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_zero) begin
               tx_cnt_next = BIT_LAST;
               if (tx_idx_reg == 3'd7) begin
`ifdef UART_CORE_PARITY_EN
                  tx_line_next  = tx_par_reg;
                  tx_state_next = TX_PARITY;
`else
                  tx_line_next  = 1'b1;
                  tx_state_next = TX_STOP;
`endif
               end else begin
                  tx_idx_next   = tx_idx_reg + 3'd1;
                  tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                  tx_line_next  = tx_shift_reg[1];
               end
            end else begin
               tx_cnt_next = tx_cnt_reg - 16'd1;
            end
         end
`ifdef UART_CORE_PARITY_EN
         TX_PARITY: begin
            if (tx_cnt_zero) begin
               tx_cnt_next   = BIT_LAST;
               tx_line_next  = 1'b1;
               tx_state_next = TX_STOP;
            end else begin
               tx_cnt_next = tx_cnt_reg - 16'd1;
            end
         end
`endif
         TX_STOP: begin
            // tx_ready is decoded here so it marks the last stop-bit cycle itself.
            if (tx_cnt_zero) begin
               tx_done       = 1'b1;
               tx_state_next = TX_IDLE;
            end else begin
               tx_cnt_next = tx_cnt_reg - 16'd1;
            end
         end
         default: begin
            tx_line_next  = 1'b1;
            tx_state_next = TX_IDLE;
         end
      endcase
   end

   assign bus.tx       = tx_line_reg;
   assign bus.tx_ready = tx_done;

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   logic        sync_a_reg, sync_b_reg;
   logic        rx_line;
   rx_state_t   rx_state_reg, rx_state_next;
   logic [15:0] rx_cnt_reg, rx_cnt_next;
   logic [2:0]  rx_idx_reg, rx_idx_next;
   logic [7:0]  rx_shift_reg, rx_shift_next;
   logic [7:0]  rx_data_reg, rx_data_next;
   logic        rx_ready_reg, rx_ready_next;
   logic        frame_err_reg, frame_err_next;
   logic        rx_armed_reg, rx_armed_next;
   logic        rx_cnt_zero;
   logic        rx_par_ok;
`ifdef UART_CORE_PARITY_EN
   logic        rx_par_reg, rx_par_next;
`endif

   assign rx_line     = sync_b_reg;
   assign rx_cnt_zero = (rx_cnt_reg == 16'd0);

`ifdef UART_CORE_PARITY_EN
   assign rx_par_ok = ((^rx_shift_reg) == rx_par_reg);
`else
   assign rx_par_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a_reg    <= 1'b1;
         sync_b_reg    <= 1'b1;
         rx_state_reg  <= RX_IDLE;
         rx_cnt_reg    <= 16'd0;
         rx_idx_reg    <= 3'd0;
         rx_shift_reg  <= 8'h00;
         rx_data_reg   <= 8'h00;
         rx_ready_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         rx_armed_reg  <= 1'b0;
`ifdef UART_CORE_PARITY_EN
         rx_par_reg    <= 1'b0;
`endif
      end else begin
         sync_a_reg    <= bus.rx;
         sync_b_reg    <= sync_a_reg;
         rx_state_reg  <= rx_state_next;
         rx_cnt_reg    <= rx_cnt_next;
         rx_idx_reg    <= rx_idx_next;
         rx_shift_reg  <= rx_shift_next;
         rx_data_reg   <= rx_data_next;
         rx_ready_reg  <= rx_ready_next;
         frame_err_reg <= frame_err_next;
         rx_armed_reg  <= rx_armed_next;
`ifdef UART_CORE_PARITY_EN
         rx_par_reg    <= rx_par_next;
`endif
      end
   end

   // rx_armed keeps a line stuck low after a bad frame from looking like a new start bit.
   always_comb begin
      rx_state_next  = rx_state_reg;
      rx_cnt_next    = rx_cnt_reg;
      rx_idx_next    = rx_idx_reg;
      rx_shift_next  = rx_shift_reg;
      rx_data_next   = rx_data_reg;
      rx_ready_next  = 1'b0;
      frame_err_next = 1'b0;
      rx_armed_next  = rx_armed_reg | rx_line;
`ifdef UART_CORE_PARITY_EN
      rx_par_next    = rx_par_reg;
`endif
      case (rx_state_reg)
         RX_IDLE: begin
            if (!rx_line && rx_armed_reg) begin
               rx_cnt_next   = HALF_LAST;
               rx_state_next = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_zero) begin
               if (rx_line) begin
                  rx_state_next = RX_IDLE;
               end else begin
                  rx_cnt_next   = BIT_LAST;
                  rx_idx_next   = 3'd0;
                  rx_state_next = RX_DATA;
               end
            end else begin
               rx_cnt_next = rx_cnt_reg - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_zero) begin
               rx_shift_next = {rx_line, rx_shift_reg[7:1]};
               rx_cnt_next   = BIT_LAST;
               if (rx_idx_reg == 3'd7) begin
`ifdef UART_CORE_PARITY_EN
                  rx_state_next = RX_PARITY;
`else
                  rx_state_next = RX_STOP;
`endif
               end else begin
                  rx_idx_next = rx_idx_reg + 3'd1;
               end
            end else begin
               rx_cnt_next = rx_cnt_reg - 16'd1;
            end
         end
`ifdef UART_CORE_PARITY_EN
         RX_PARITY: begin
            if (rx_cnt_zero) begin
               rx_par_next   = rx_line;
               rx_cnt_next   = BIT_LAST;
               rx_state_next = RX_STOP;
            end else begin
               rx_cnt_next = rx_cnt_reg - 16'd1;
            end
         end
`endif
         RX_STOP: begin
            if (rx_cnt_zero) begin
               rx_state_next = RX_IDLE;
               if (rx_line && rx_par_ok) begin
                  rx_data_next  = rx_shift_reg;
                  rx_ready_next = 1'b1;
               end else begin
                  frame_err_next = 1'b1;
                  rx_armed_next  = 1'b0;
               end
            end else begin
               rx_cnt_next = rx_cnt_reg - 16'd1;
            end
         end
         default: begin
            rx_state_next = RX_IDLE;
         end
      endcase
   end

   assign bus.rx_data   = rx_data_reg;
   assign bus.rx_ready  = rx_ready_reg;
   assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_core.sv
// Directed-plus-random bench for uart_core at CLKS_PER_BIT=8; frames are modelled as bit vectors.
// Honours UART_CORE_PARITY_EN the same way as the design.
module tb_uart_core;

   localparam int CPB = 8;
`ifdef UART_CORE_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic clk = 1'b0;
   logic reset;
   logic loop_en;
   logic rx_drv;

   int checks = 0;
   int failures = 0;
   int tx_ready_cnt = 0;
   int rx_ready_cnt = 0;
   int frame_err_cnt = 0;
   logic [7:0] model_rx;

   uart_core_if bus ();

   uart_core #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   assign bus.rx = loop_en ? bus.tx : rx_drv;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.tx_ready === 1'b1) tx_ready_cnt++;
      if (bus.rx_ready === 1'b1) rx_ready_cnt++;
      if (bus.frame_err === 1'b1) frame_err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line levels of one frame in transmission order: start, data LSB first, [parity], stop.
   function automatic logic [NBITS-1:0] frame_of(input logic [7:0] d, input logic stop,
                                                  input logic par_flip);
      logic [NBITS-1:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_CORE_PARITY_EN
      f[9]  = (^d) ^ par_flip;
      f[10] = stop;
`else
      f[9] = stop;
`endif
      return f;
   endfunction

   // Called just after a falling edge; returns just after a falling edge.
   task automatic send_tx(input logic [7:0] d, input int inject_at, input logic [7:0] inj_d,
                          input string tag);
      logic [NBITS-1:0] exp_f;
      logic obs [NBITS];
      int hits;
      int pos;
      exp_f = frame_of(d, 1'b1, 1'b0);
      hits = 0;
      pos = -1;
      bus.tx_req = 1'b1;
      bus.tx_data = d;
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         if (k % CPB == 0) obs[k/CPB] = bus.tx;
         else if (obs[k/CPB] !== bus.tx) obs[k/CPB] = 1'bx;
         if (bus.tx_ready === 1'b1) begin
            hits++;
            pos = k;
         end
         if (k == inject_at) begin
            bus.tx_req = 1'b1;
            bus.tx_data = inj_d;
         end else begin
            bus.tx_req = 1'b0;
         end
      end
      for (int b = 0; b < NBITS; b++)
         check($sformatf("%s_bit%0d", tag, b), {31'b0, obs[b]}, {31'b0, exp_f[b]});
      check({tag, "_ready_hits"}, hits, 1);
      check({tag, "_ready_pos"}, pos, FRAME - 1);
      @(negedge clk);
      bus.tx_req = 1'b0;
      check({tag, "_idle_after"}, {31'b0, bus.tx}, 32'd1);
   endtask

   task automatic rx_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                           input int hold, input int tail);
      logic [NBITS-1:0] f;
      f = frame_of(d, stop, par_flip);
      for (int b = 0; b < NBITS; b++) begin
         rx_drv = f[b];
         repeat (CPB) @(negedge clk);
      end
      repeat (hold) @(negedge clk);
      rx_drv = 1'b1;
      repeat (tail) @(negedge clk);
   endtask

   task automatic expect_rx(input string tag, input int r0, input int e0,
                            input int dr, input int de);
      check({tag, "_rx_ready"}, rx_ready_cnt - r0, dr);
      check({tag, "_frame_err"}, frame_err_cnt - e0, de);
      check({tag, "_rx_data"}, {24'b0, bus.rx_data}, {24'b0, model_rx});
   endtask

   initial begin
      int r0, e0, t0;
      logic [7:0] d, d2;
      reset = 1'b1;
      loop_en = 1'b0;
      rx_drv = 1'b1;
      bus.tx_req = 1'b0;
      bus.tx_data = 8'h00;
      model_rx = 8'h00;

      repeat (3) @(negedge clk);
      check("rst_tx", {31'b0, bus.tx}, 32'd1);
      check("rst_rx_data", {24'b0, bus.rx_data}, 32'd0);
      check("rst_tx_ready", {31'b0, bus.tx_ready}, 32'd0);
      check("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
      check("rst_frame_err", {31'b0, bus.frame_err}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rel_pulses", {29'b0, bus.tx_ready, bus.rx_ready, bus.frame_err}, 32'd0);

      send_tx(8'hA5, -1, 8'h00, "tx_a5");

      // Request during the ready cycle is dropped, the one right after is taken.
      send_tx(8'($urandom), FRAME - 1, 8'($urandom), "tx_busy_last");
      send_tx(8'($urandom), -1, 8'h00, "tx_next_cycle");

      t0 = tx_ready_cnt;
      send_tx(8'hFF, 20, 8'h00, "tx_ff_inj");
      check("tx_ff_one_ready", tx_ready_cnt - t0, 1);

      loop_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = (i == 0) ? 8'h3C : 8'($urandom);
         r0 = rx_ready_cnt;
         e0 = frame_err_cnt;
         send_tx(d, -1, 8'h00, $sformatf("loop%0d", i));
         repeat (2 * CPB) @(negedge clk);
         model_rx = d;
         expect_rx($sformatf("loop%0d", i), r0, e0, 1, 0);
      end
      loop_en = 1'b0;
      repeat (4) @(negedge clk);

      r0 = rx_ready_cnt;
      e0 = frame_err_cnt;
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      expect_rx("glitch", r0, e0, 0, 0);
      rx_frame(8'h81, 1'b1, 1'b0, 0, 2 * CPB);
      model_rx = 8'h81;
      expect_rx("rx_81", r0, e0, 1, 0);

      r0 = rx_ready_cnt;
      e0 = frame_err_cnt;
      rx_frame(8'h55, 1'b0, 1'b0, 0, 2 * CPB);
      expect_rx("bad_stop", r0, e0, 0, 1);

      r0 = rx_ready_cnt;
      e0 = frame_err_cnt;
      rx_frame(8'h5A, 1'b0, 1'b0, 3 * CPB, 12 * CPB);
      expect_rx("held_low", r0, e0, 0, 1);

      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom);
         r0 = rx_ready_cnt;
         e0 = frame_err_cnt;
         repeat ($urandom_range(0, 5)) @(negedge clk);
         rx_frame(d, 1'b1, 1'b0, 0, 2 * CPB);
         model_rx = d;
         expect_rx($sformatf("rx_rand%0d", i), r0, e0, 1, 0);
      end

      // Both directions at once.
      d = 8'($urandom);
      d2 = 8'($urandom);
      r0 = rx_ready_cnt;
      e0 = frame_err_cnt;
      fork
         send_tx(d, -1, 8'h00, "duplex_tx");
         rx_frame(d2, 1'b1, 1'b0, 0, 2 * CPB);
      join
      model_rx = d2;
      expect_rx("duplex_rx", r0, e0, 1, 0);

`ifdef UART_CORE_PARITY_EN
      send_tx(8'h07, -1, 8'h00, "par_07");
      r0 = rx_ready_cnt;
      e0 = frame_err_cnt;
      rx_frame(8'h07, 1'b1, 1'b1, 0, 2 * CPB);
      expect_rx("par_bad", r0, e0, 0, 1);
      d = 8'($urandom);
      rx_frame(d, 1'b1, 1'b0, 0, 2 * CPB);
      model_rx = d;
      expect_rx("par_good", r0, e0, 1, 1);
`endif

      // Abort a loopback frame 40 cycles in with an asynchronous reset.
      loop_en = 1'b1;
      t0 = tx_ready_cnt;
      r0 = rx_ready_cnt;
      e0 = frame_err_cnt;
      bus.tx_req = 1'b1;
      bus.tx_data = 8'($urandom);
      @(negedge clk);
      bus.tx_req = 1'b0;
      repeat (39) @(negedge clk);
      check("pre_abort_tx_low", {31'b0, bus.tx === 1'b0 || bus.tx === 1'b1}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_tx", {31'b0, bus.tx}, 32'd1);
      check("abort_tx_ready", {31'b0, bus.tx_ready}, 32'd0);
      check("abort_rx_data", {24'b0, bus.rx_data}, 32'd0);
      model_rx = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_rel_pulses", {29'b0, bus.tx_ready, bus.rx_ready, bus.frame_err}, 32'd0);
      repeat (2 * CPB) @(negedge clk);
      check("abort_no_tx_ready", tx_ready_cnt - t0, 0);
      expect_rx("abort", r0, e0, 0, 0);
      d = 8'($urandom);
      send_tx(d, -1, 8'h00, "post_abort");
      repeat (2 * CPB) @(negedge clk);
      model_rx = d;
      expect_rx("post_abort", r0, e0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), giving clk cycles per serial bit, legal range 4..65535.
REQ-002 Port clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port reset  input  1  reset, asynchronous, active-high.
REQ-004 Port tx_req  input  1  one-cycle request to transmit tx_data.
REQ-005 Port tx_data  input  8  byte to transmit, sampled on the tx_req cycle.
REQ-006 Port rx  input  1  asynchronous serial input line, idle high.
REQ-007 Port tx  output  1  serial output line, idle high.
REQ-008 Port rx_data  output  8  last correctly received byte.
REQ-009 Port tx_ready  output  1  one-cycle pulse, transmit frame complete.
REQ-010 Port rx_ready  output  1  one-cycle pulse, new byte valid on rx_data.
REQ-011 Port frame_err  output  1  one-cycle pulse, received frame rejected.

Function
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-028), 1 stop bit (1).
REQ-013 TX FSM states SHALL be IDLE, START, DATA, PARITY (only with the macro), STOP; one down-counter per bit of CLKS_PER_BIT cycles, 3-bit bit index.
REQ-014 tx_req in IDLE SHALL latch tx_data into a shift register; tx SHALL go low on the next clk edge and stay low for exactly CLKS_PER_BIT cycles.
REQ-015 tx_req outside IDLE SHALL be ignored; the frame in progress SHALL be unaffected, with no queuing.
REQ-016 tx_ready SHALL pulse high for one cycle on the last cycle of the stop bit, with the FSM in IDLE on the following edge; a tx_req in the tx_ready cycle SHALL NOT be accepted, and a tx_req on the next cycle SHALL be.
REQ-017 Total tx frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), measured from the first low cycle to the tx_ready cycle inclusive.
REQ-018 rx SHALL pass through a two-flop synchronizer; all RX decisions SHALL use the synchronized value, adding 2 cycles of latency.
REQ-019 RX FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-020 Leaving IDLE: a synchronized low SHALL enter START; after CLKS_PER_BIT/2 cycles (integer division), the line SHALL be resampled; if high, the FSM SHALL return to IDLE (false start) with no pulse.
REQ-021 Each subsequent bit SHALL be sampled once, CLKS_PER_BIT cycles after the previous sample point (mid-bit); glitches between sample points SHALL be ignored.
REQ-022 At the stop sample: if high (and parity correct), rx_data SHALL be updated and rx_ready SHALL pulse on the same edge; if low, or on a parity mismatch, rx_data SHALL be unchanged and frame_err SHALL pulse instead; either way the FSM SHALL return to IDLE.
REQ-023 After a framing error with rx held low, the RX FSM SHALL NOT re-trigger until rx has been high for at least one synchronized cycle.
REQ-024 rx_data SHALL hold its value until the next valid frame; TX and RX SHALL operate fully independently and simultaneously (loopback allowed).

Reset
REQ-025 Asserting reset SHALL immediately force: tx=1, rx_data=8'h00, tx_ready=0, rx_ready=0, frame_err=0, both FSMs IDLE, counters and synchronizer flops cleared (synchronizer flops set to 1).
REQ-026 Reset mid-frame SHALL abort both frames with no pulse; after reset release, the first tx_req SHALL start a full fresh frame.
REQ-027 No output SHALL pulse in the first cycle after reset release.

Configuration
REQ-028 Macro UART_CORE_PARITY_EN defined: an even parity bit (XOR of the 8 data bits) SHALL be sent after bit 7 and checked on RX, with a mismatch giving frame_err; macro undefined: no PARITY state and no parity bit, giving 10-bit frames.

Verification (CLKS_PER_BIT=8)
REQ-029 Reset, then tx_req with tx_data=8'hA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each 8 cycles; tx_ready pulses exactly once, 80 cycles after tx went low.
REQ-030 Loopback tx->rx, send 8'h3C -> rx_ready pulses once with rx_data=8'h3C, frame_err never high.
REQ-031 Drive rx low for 3 cycles, then high -> no rx_ready or frame_err; a following valid 8'h81 frame is received correctly.
REQ-032 Drive a frame 8'h55 with stop bit=0 -> frame_err pulses once, rx_data keeps its previous value, rx_ready stays 0.
REQ-033 tx_req with 8'hFF, then tx_req with 8'h00 at cycle 20 -> the second request is ignored and only one tx_ready pulse occurs; assert reset at cycle 40 of a new frame -> tx=1 immediately, no tx_ready.
REQ-034 With UART_CORE_PARITY_EN, send 8'h07 -> parity bit 1 and frame length 88 cycles; inject a frame 8'h07 with parity 0 -> frame_err pulses.
